// File: rtl/eve_pkg.sv
// Shared types and constants for the EvE child collector: FSM states, slot
// encoding and the lowest-enabled-slot helper.
package eve_pkg;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  localparam int GENOME_W  = 64;
  localparam int NUM_SLOTS = 3;
  localparam int SLOT_W    = 2;

  localparam logic [SLOT_W-1:0] SLOT_OUT1 = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_OUT2 = 2'd1;
  localparam logic [SLOT_W-1:0] SLOT_OUT3 = 2'd2;

  function automatic logic [SLOT_W-1:0] lowest_slot(input logic [NUM_SLOTS-1:0] mask);
    logic [SLOT_W-1:0] slot;
    if (mask[0]) begin
      slot = SLOT_OUT1;
    end else if (mask[1]) begin
      slot = SLOT_OUT2;
    end else begin
      slot = SLOT_OUT3;
    end
    return slot;
  endfunction

endpackage

// File: rtl/eve_next_slot.sv
// Slot sequencer: picks the next enabled slot after the current one, or the
// first enabled slot when searching from the start of a PE.
module eve_next_slot
  import eve_pkg::*;
(
  input  logic [SLOT_W-1:0]    i_cur_slot,
  input  logic [NUM_SLOTS-1:0] i_mask,
  input  logic                 i_last_pe,
  input  logic                 i_from_start,
  output logic [SLOT_W-1:0]    o_next_slot,
  output logic                 o_pe_inc,
  output logic                 o_is_last
);

  logic [NUM_SLOTS-1:0] w_above;
  logic [NUM_SLOTS-1:0] w_cand;

  // Search the enabled slots above the current one; wrap to the next PE when none remain
  always_comb begin
    w_above     = 3'b000;
    w_cand      = 3'b000;
    o_next_slot = SLOT_OUT1;
    o_pe_inc    = 1'b0;
    case (i_cur_slot)
      SLOT_OUT1: w_above = 3'b110;
      SLOT_OUT2: w_above = 3'b100;
      default:   w_above = 3'b000;
    endcase
    if (i_from_start) begin
      w_cand = i_mask;
    end else begin
      w_cand = i_mask & w_above;
    end
    if (w_cand != 3'b000) begin
      o_next_slot = lowest_slot(w_cand);
      o_pe_inc    = 1'b0;
    end else begin
      o_next_slot = lowest_slot(i_mask);
      o_pe_inc    = 1'b1;
    end
    o_is_last = o_pe_inc & i_last_pe;
  end

endmodule

// File: rtl/eve_child_collector.sv
// Snapshots the three child words of every PE on capture and drains them as a
// tagged valid/ready stream, PE-major and slot-minor.
module eve_child_collector
  import eve_pkg::*;
#(
  parameter int num_PE  = 8,
  parameter int PE_ID_W = 8
) (
  input  logic                         input_clk,
  input  logic                         reset,
  input  logic                         capture,
  input  logic [GENOME_W*num_PE-1:0]   in1,
  input  logic [GENOME_W*num_PE-1:0]   in2,
  input  logic [GENOME_W*num_PE-1:0]   in3,
  input  logic [NUM_SLOTS-1:0]         slot_en,
  output logic [GENOME_W-1:0]          out_data,
  output logic [PE_ID_W-1:0]           out_pe_id,
  output logic [SLOT_W-1:0]            out_slot,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int PIDX_W = (num_PE > 1) ? $clog2(num_PE) : 1;
  localparam logic [PIDX_W-1:0] LAST_PE = PIDX_W'(num_PE - 1);
  localparam logic [PIDX_W-1:0] PE_ONE  = PIDX_W'(1);
  localparam logic [PIDX_W-1:0] PE_ZERO = PIDX_W'(0);

  state_t                       r_state;
  logic [GENOME_W*num_PE-1:0]   r_sh1, r_sh2, r_sh3;
  logic [NUM_SLOTS-1:0]         r_mask;
  logic [PIDX_W-1:0]            r_pe;
  logic [SLOT_W-1:0]            r_slot;
  logic [GENOME_W-1:0]          r_data;
  logic [PE_ID_W-1:0]           r_pe_id;
  logic                         r_valid, r_busy, r_done, r_ovf;

  logic                         w_idle;
  logic [NUM_SLOTS-1:0]         w_mask;
  logic [SLOT_W-1:0]            w_next_slot;
  logic                         w_pe_inc, w_is_last;
  logic [PIDX_W-1:0]            w_next_pe;
  logic [GENOME_W-1:0]          w_cap_word, w_drain_word;

  function automatic logic [GENOME_W-1:0] pick(
    input logic [GENOME_W*num_PE-1:0] a,
    input logic [GENOME_W*num_PE-1:0] b,
    input logic [GENOME_W*num_PE-1:0] c,
    input logic [PIDX_W-1:0]          pe,
    input logic [SLOT_W-1:0]          slot
  );
    logic [GENOME_W-1:0] word;
    case (slot)
      SLOT_OUT1: word = a[{pe, 6'd0} +: GENOME_W];
      SLOT_OUT2: word = b[{pe, 6'd0} +: GENOME_W];
      default:   word = c[{pe, 6'd0} +: GENOME_W];
    endcase
    return word;
  endfunction

  // In IDLE the sequencer looks at the live mask to find the first slot of a new capture
  assign w_idle = (r_state == IDLE);
  assign w_mask = w_idle ? slot_en : r_mask;

  eve_next_slot u_next_slot (
    .i_cur_slot   (r_slot),
    .i_mask       (w_mask),
    .i_last_pe    (r_pe == LAST_PE),
    .i_from_start (w_idle),
    .o_next_slot  (w_next_slot),
    .o_pe_inc     (w_pe_inc),
    .o_is_last    (w_is_last)
  );

  // Next pointer PE; wraps to 0 past the last PE so the shadow select stays in range
  always_comb begin
    w_next_pe = r_pe;
    if (w_pe_inc) begin
      if (w_is_last) begin
        w_next_pe = PE_ZERO;
      end else begin
        w_next_pe = r_pe + PE_ONE;
      end
    end else begin
      w_next_pe = r_pe;
    end
  end

  assign w_cap_word   = pick(in1, in2, in3, PE_ZERO, w_next_slot);
  assign w_drain_word = pick(r_sh1, r_sh2, r_sh3, w_next_pe, w_next_slot);

  // Snapshot storage is deliberately left out of reset
  always_ff @(posedge input_clk) begin
    if (w_idle && capture) begin
      r_sh1  <= in1;
      r_sh2  <= in2;
      r_sh3  <= in3;
      r_mask <= slot_en;
    end
  end

  // Collector FSM with registered stream outputs
  always_ff @(posedge input_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_data  <= {GENOME_W{1'b0}};
      r_pe_id <= {PE_ID_W{1'b0}};
      r_slot  <= SLOT_OUT1;
      r_pe    <= PE_ZERO;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (capture) begin
            if (slot_en == 3'b000) begin
              r_done <= 1'b1;
            end else begin
              r_state <= DRAIN;
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_pe    <= PE_ZERO;
              r_slot  <= w_next_slot;
              r_data  <= w_cap_word;
              r_pe_id <= {PE_ID_W{1'b0}};
            end
          end
        end
        DRAIN: begin
          if (capture) begin
            r_ovf <= 1'b1;
          end
          if (r_valid && out_ready) begin
            if (w_is_last) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_pe    <= w_next_pe;
              r_slot  <= w_next_slot;
              r_data  <= w_drain_word;
              r_pe_id <= PE_ID_W'(w_next_pe);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_pe_id = r_pe_id;
  assign out_slot  = r_slot;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_eve_child_collector.sv
// Randomized and directed bench for eve_child_collector against a queue-based
// model of the drained word stream.
module tb_eve_child_collector;

  localparam int NPE = 8;

  logic              clk = 1'b0;
  logic              reset, capture, out_ready;
  logic [64*NPE-1:0] in1, in2, in3;
  logic [2:0]        slot_en;
  logic [63:0]       out_data;
  logic [7:0]        out_pe_id;
  logic [1:0]        out_slot;
  logic              out_valid, busy, done, overflow;

  eve_child_collector #(.num_PE(NPE), .PE_ID_W(8)) dut (
    .input_clk (clk),
    .reset     (reset),
    .capture   (capture),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .slot_en   (slot_en),
    .out_data  (out_data),
    .out_pe_id (out_pe_id),
    .out_slot  (out_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  pe;
    logic [1:0]  s;
  } word_t;

  word_t       q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, cap_cyc = 0, done_cyc = 0, hs = 0;
  logic [63:0] first_data = 64'd0, last_data = 64'd0;
  bit          started = 1'b0, m_done = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
  bit          prev_stall = 1'b0, rand_rdy = 1'b0;
  logic [73:0] prev_word = 74'd0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, then advance the model with the inputs of the coming edge
  always @(negedge clk) begin
    bit nd;
    cyc++;
    if (started) begin
      chk("valid", 80'(out_valid), 80'(q.size() != 0));
      chk("busy", 80'(busy), 80'(q.size() != 0));
      chk("done", 80'(done), 80'(m_done));
      chk("overflow", 80'(overflow), 80'(m_ovf));
      if (q.size() != 0) begin
        chk("data", 80'(out_data), 80'(q[0].d));
        chk("pe_id", 80'(out_pe_id), 80'(q[0].pe));
        chk("slot", 80'(out_slot), 80'(q[0].s));
      end else if (m_zero) begin
        chk("rst_outs", 80'({out_data, out_pe_id, out_slot}), 80'd0);
      end
      if (prev_stall) chk("stall_hold", 80'({out_data, out_pe_id, out_slot}), 80'(prev_word));
      if (done) done_cyc = cyc;
    end
    nd = 1'b0;
    if (reset) begin
      started = 1'b1;
      q.delete();
      m_ovf = 1'b0;
      m_zero = 1'b1;
      prev_stall = 1'b0;
    end else if (started) begin
      if (q.size() != 0) begin
        if (capture) m_ovf = 1'b1;
        prev_stall = !out_ready;
        prev_word = {out_data, out_pe_id, out_slot};
        if (out_ready) begin
          if (hs == 0) first_data = q[0].d;
          last_data = q[0].d;
          hs++;
          void'(q.pop_front());
          if (q.size() == 0) nd = 1'b1;
        end
      end else begin
        prev_stall = 1'b0;
        if (capture) begin
          cap_cyc = cyc;
          hs = 0;
          if (slot_en == 3'b000) nd = 1'b1;
          else m_zero = 1'b0;
          for (int p = 0; p < NPE; p++) begin
            if (slot_en[0]) q.push_back('{in1[64*p +: 64], 8'(p), 2'd0});
            if (slot_en[1]) q.push_back('{in2[64*p +: 64], 8'(p), 2'd1});
            if (slot_en[2]) q.push_back('{in3[64*p +: 64], 8'(p), 2'd2});
          end
        end
      end
    end
    m_done = nd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b1;
  endtask

  task automatic pulse_cap(input logic [2:0] m);
    slot_en = m;
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(nm, 80'(done), 80'd1);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs < target && n < 200) begin
      tick();
      n++;
    end
    chk("wait_hs", 80'(hs >= target), 80'd1);
  endtask

  task automatic set_pattern();
    for (int r = 0; r < NPE; r++) begin
      in1[64*r +: 64] = 64'h1000 + 64'(r);
      in2[64*r +: 64] = 64'h2000 + 64'(r);
      in3[64*r +: 64] = 64'h3000 + 64'(r);
    end
  endtask

  task automatic drain_checks(input string nm, input int words, input logic [63:0] last);
    chk({nm, "_words"}, 80'(hs), 80'(words));
    chk({nm, "_latency"}, 80'(done_cyc - cap_cyc), 80'(words + 1));
    chk({nm, "_first"}, 80'(first_data), 80'h1000);
    chk({nm, "_last"}, 80'(last_data), 80'(last));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; capture = 1'b0; slot_en = 3'b000; out_ready = 1'b1;
    set_pattern();
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", 80'(out_valid), 80'd0);
    chk("rst_data", 80'(out_data), 80'd0);
    chk("rst_ovf", 80'(overflow), 80'd0);

    // full drain with the consumer always ready
    pulse_cap(3'b111);
    chk("first_word_lat1", 80'({out_valid, out_data}), {15'd0, 1'b1, 64'h1000});
    wait_done(100, "full_done");
    tick();
    drain_checks("full", 24, 64'h3007);

    // sparse mask: slots 0 and 2 only
    pulse_cap(3'b101);
    wait_done(100, "sparse_done");
    tick();
    drain_checks("sparse", 16, 64'h3007);

    // random backpressure
    rand_rdy = 1'b1;
    pulse_cap(3'b111);
    wait_done(500, "bp_done");
    tick();
    chk("bp_words", 80'(hs), 80'd24);
    chk("bp_last", 80'(last_data), 80'h3007);
    rand_rdy = 1'b0;
    tick();

    // capture mid-drain with new input data: ignored but flagged
    pulse_cap(3'b111);
    wait_hs(5);
    in1 = '1; in2 = '1; in3 = '1;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    set_pattern();
    wait_done(100, "ovf_done");
    tick();
    chk("ovf_words", 80'(hs), 80'd24);
    chk("ovf_last", 80'(last_data), 80'h3007);
    tick(); tick();
    chk("ovf_sticky", 80'(overflow), 80'd1);

    // empty mask after reset
    reset = 1'b1; tick(); reset = 1'b0;
    pulse_cap(3'b000);
    wait_done(5, "empty_done");
    tick();
    chk("empty_latency", 80'(done_cyc - cap_cyc), 80'd1);
    chk("empty_words", 80'(hs), 80'd0);
    chk("empty_busy", 80'(busy), 80'd0);

    // reset mid-drain, then restart
    pulse_cap(3'b111);
    wait_hs(10);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_valid", 80'(out_valid), 80'd0);
    chk("midrst_done", 80'(done), 80'd0);
    tick();
    pulse_cap(3'b111);
    chk("restart_word", 80'({out_data, out_pe_id, out_slot}), {6'd0, 64'h1000, 8'd0, 2'd0});
    wait_done(100, "restart_done");

    // capture during the done cycle is accepted
    slot_en = 3'b111;
    capture = 1'b1;
    tick();
    capture = 1'b0;
    chk("donecap_busy", 80'(busy), 80'd1);
    chk("donecap_ovf", 80'(overflow), 80'd0);
    wait_done(100, "donecap_done");
    tick();
    chk("donecap_words", 80'(hs), 80'd24);

    // random data, masks and backpressure
    rand_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < NPE; r++) begin
        in1[64*r +: 64] = {$urandom, $urandom};
        in2[64*r +: 64] = {$urandom, $urandom};
        in3[64*r +: 64] = {$urandom, $urandom};
      end
      pulse_cap(3'($urandom_range(0, 7)));
      wait_done(500, "rand_done");
      tick();
    end
    rand_rdy = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
